// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: TX state encoding, line levels and parity-type encodings
// (the parity encodings are also used by the RX parity checker).
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam logic StartBit  = 1'b0;
  localparam logic StopBit   = 1'b1;
  localparam logic IdleLevel = 1'b1;

  localparam logic ParEven = 1'b0;
  localparam logic ParOdd  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load-on-accept shift register and bit counter; ser_done_o pulses on the shift that
// puts the last payload bit on the line.
module uart_tx_serializer #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 shift_i,
  output logic                 bit_o,
  output logic                 ser_done_o
);

  localparam int unsigned CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DataWidth - 1);

  logic [DataWidth-1:0] shift_q, shift_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shift_d = shift_q >> 1;
      cnt_d   = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_o      = shift_q[0];
  assign ser_done_o = shift_i && (cnt_q == LastCnt);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one bit per clk; start, LSB-first data, optional parity, one stop bit.
// TX_OUT and Busy are registered and change only with the FSM state.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      par_en_q, par_en_d;
  logic      par_bit_q, par_bit_d;
  logic      last_q, last_d;
  logic      accept, shift, ser_bit, ser_done;

  uart_tx_serializer #(
    .DataWidth(DATA_WIDTH)
  ) u_serializer (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (accept),
    .data_i    (P_DATA),
    .shift_i   (shift),
    .bit_o     (ser_bit),
    .ser_done_o(ser_done)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    last_d    = last_q;
    accept    = 1'b0;
    shift     = 1'b0;

    // tx_d/busy_d describe the state being entered, so the line is flop-driven.
    case (state_q)
      StIdle: begin
        tx_d   = IdleLevel;
        busy_d = 1'b0;
        accept = DATA_VALID;
      end
      StStart: begin
        state_d = StData;
        tx_d    = ser_bit;
        shift   = 1'b1;
        last_d  = ser_done;
      end
      StData: begin
        if (last_q) begin
          last_d = 1'b0;
          if (par_en_q) begin
            state_d = StParity;
            tx_d    = par_bit_q;
          end else begin
            state_d = StStop;
            tx_d    = StopBit;
          end
        end else begin
          tx_d   = ser_bit;
          shift  = 1'b1;
          last_d = ser_done;
        end
      end
      StParity: begin
        state_d = StStop;
        tx_d    = StopBit;
      end
      StStop: begin
        state_d = StIdle;
        tx_d    = IdleLevel;
        busy_d  = 1'b0;
        accept  = DATA_VALID;
      end
      default: begin
        state_d = StIdle;
        tx_d    = IdleLevel;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    // Leaving STOP with a request pending goes straight to START (back-to-back frames).
    if (accept) begin
      state_d   = StStart;
      tx_d      = StartBit;
      busy_d    = 1'b1;
      last_d    = 1'b0;
      par_en_d  = PAR_EN;
      par_bit_d = (PAR_TYP == ParEven) ? ^P_DATA : ~^P_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      tx_q      <= IdleLevel;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      last_q    <= last_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboarded bench for uart_tx_frame: a frame-level model predicts accepted requests and
// their line bits; a line monitor reassembles frames and compares them.
module tb_uart_tx_frame;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] p_data = '0;
  logic         dv = 1'b0;
  logic         par_en = 1'b0;
  logic         par_typ = 1'b0;
  logic         tx_out;
  logic         busy;

  always #5 clk = ~clk;

  uart_tx_frame #(
    .DATA_WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .P_DATA    (p_data),
    .DATA_VALID(dv),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .TX_OUT    (tx_out),
    .Busy      (busy)
  );

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          start_cyc;
  } frame_t;

  frame_t exp_q[$];
  int     cyc = 0;
  int     free_at = 0;
  int     n_acc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Line image of a frame: bit i is the level during the i-th bit time.
  function automatic frame_t make_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                                        input int at);
    frame_t f;
    int     ones;
    ones   = 0;
    f.bits = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < W; i++) begin
      f.bits[1 + i] = d[i];
      ones += int'(d[i]);
    end
    f.len = W + 2 + (pe ? 1 : 0);
    if (pe) f.bits[W + 1] = ((ones % 2) == 1) ^ pt;
    f.start_cyc = at;
    return f;
  endfunction

  // Reference model: a request is taken on any edge once the previous frame's length has elapsed.
  always @(posedge clk) begin
    cyc++;
    if (rst && dv && cyc >= free_at) begin
      exp_q.push_back(make_frame(p_data, par_en, par_typ, cyc));
      free_at = cyc + W + 2 + (par_en ? 1 : 0);
      n_acc++;
    end
  end

  logic        in_frame = 1'b0;
  logic        busy_ok;
  logic [15:0] got_bits;
  int          idx;
  frame_t      cur;

  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 1'b0;
      check("reset_line", {30'd0, tx_out, busy}, 32'h2);
    end else if (in_frame) begin
      got_bits[idx] = tx_out;
      if (busy !== 1'b1) busy_ok = 1'b0;
      idx++;
      if (idx == cur.len) begin
        check("frame_bits", {16'd0, got_bits}, {16'd0, cur.bits});
        check("frame_busy", {31'd0, busy_ok}, 32'd1);
        in_frame = 1'b0;
      end
    end else if (busy === 1'b1 && tx_out === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        check("frame_start_cycle", cyc, cur.start_cyc);
        got_bits    = '1;
        got_bits[0] = 1'b0;
        idx         = 1;
        busy_ok     = 1'b1;
        in_frame    = 1'b1;
      end
    end else begin
      check("idle_line", {30'd0, tx_out, busy}, 32'h2);
    end
  end

  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
    @(negedge clk);
    p_data  = d;
    par_en  = pe;
    par_typ = pt;
    dv      = 1'b1;
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !in_frame && cyc >= free_at) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 30; i++) begin
      if (n_acc >= target) return;
      @(negedge clk);
    end
    check("accept_timeout", n_acc, target);
  endtask

  int acc_before;

  initial begin
    // Reset held with a request pending: nothing may start.
    rst    = 1'b0;
    dv     = 1'b1;
    p_data = 8'h5A;
    repeat (3) @(negedge clk);
    dv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("no_accept_in_reset", n_acc, 0);

    send(8'hA5, 1'b0, 1'b0);
    wait_idle();
    send(8'hA5, 1'b1, 1'b0);
    wait_idle();
    send(8'hA5, 1'b1, 1'b1);
    wait_idle();
    send(8'h07, 1'b1, 1'b0);
    wait_idle();

    // Input changes and a request mid-frame are ignored.
    acc_before = n_acc;
    send(8'h3C, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    p_data = 8'hFF;
    par_en = 1'b1;
    dv     = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    wait_idle();
    check("no_extra_accept", n_acc, acc_before + 1);

    // Held request: back-to-back frames with per-acceptance payloads.
    acc_before = n_acc;
    @(negedge clk);
    p_data = 8'h55;
    par_en = 1'b0;
    dv     = 1'b1;
    wait_acc(acc_before + 1);
    @(negedge clk);
    p_data = 8'hAA;
    wait_acc(acc_before + 2);
    @(negedge clk);
    dv = 1'b0;
    wait_idle();
    check("b2b_accepts", n_acc, acc_before + 2);

    // Asynchronous reset while bit 3 of 0xF0 is on the line.
    send(8'hF0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    free_at = 0;
    #1;
    check("async_reset_tx", {31'd0, tx_out}, 32'd1);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(8'hC3, 1'b1, 1'b1);
    wait_idle();

    // Random requests: varied hold lengths, payload churn while held, random parity.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      p_data  = W'($urandom);
      par_en  = 1'($urandom);
      par_typ = 1'($urandom);
      dv      = 1'b1;
      for (int h = $urandom_range(1, 14); h > 0; h--) begin
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) p_data = W'($urandom);
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
      end
      dv = 1'b0;
      if ($urandom_range(0, 3) == 0) wait_idle();
    end

    wait_idle();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
